// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational fetch lookup, E-stage training, mispredict flag and saturating statistics.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredictF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        PCSrcE,
  input  logic [31:0] TargetE,
  input  logic        PredictedE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  input  logic        ClrStats,
  output logic [15:0] BranchCnt,
  output logic [15:0] MissCnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Counter encodings: SN=00, WN=01, WT=10, ST=11
  localparam logic [1:0] CTR_WT = 2'b10;

  logic [ENTRIES-1:0]      validQ;
  logic [ENTRIES-1:0][1:0] ctrQ;
  logic [TAG_BITS-1:0]     tagQ    [ENTRIES];
  logic [31:0]             targetQ [ENTRIES];
  logic [15:0]             branchCntQ;
  logic [15:0]             missCntQ;

  logic [IDX_BITS-1:0] idxF;
  logic [IDX_BITS-1:0] idxE;
  logic [TAG_BITS-1:0] tagF;
  logic [TAG_BITS-1:0] tagE;
  logic                hitF;
  logic                hitE;
  logic                mispredictRaw;
  logic                unusedPcBits;

  function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign idxF = PCF[IDX_BITS+1:2];
  assign tagF = PCF[31:IDX_BITS+2];
  assign idxE = PCE[IDX_BITS+1:2];
  assign tagE = PCE[31:IDX_BITS+2];

  // PCs are word aligned, so the byte-offset bits carry no information.
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup: reads pre-update contents, no bypass from a same-cycle write.
  assign hitF        = validQ[idxF] & (tagQ[idxF] == tagF);
  assign PredictF    = hitF & ctrQ[idxF][1];
  assign PredTargetF = PredictF ? targetQ[idxF] : 32'd0;

  assign hitE = validQ[idxE] & (tagQ[idxE] == tagE);

  assign mispredictRaw = UpdateE & ((PredictedE ^ PCSrcE) |
                                    (PredictedE & PCSrcE & (PredTargetE != TargetE)));
  assign MispredictE   = rst_n & mispredictRaw;

  // Table control state: valid bits and direction counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validQ <= '0;
      ctrQ   <= '0;
    end else if (UpdateE) begin
      if (hitE) begin
        ctrQ[idxE] <= ctrNext(ctrQ[idxE], PCSrcE);
      end else if (PCSrcE) begin
        validQ[idxE] <= 1'b1;
        ctrQ[idxE]   <= CTR_WT;
      end
    end
  end

  // Table data: tag and target only change on a taken resolution, hit or allocate.
  always_ff @(posedge clk) begin
    if (rst_n && UpdateE && PCSrcE) begin
      tagQ[idxE]    <= tagE;
      targetQ[idxE] <= TargetE;
    end
  end

  // Statistics; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || ClrStats) begin
      branchCntQ <= '0;
      missCntQ   <= '0;
    end else if (UpdateE) begin
      branchCntQ <= satInc16(branchCntQ);
      if (mispredictRaw)
        missCntQ <= satInc16(missCntQ);
    end
  end

  assign BranchCnt = branchCntQ;
  assign MissCnt   = missCntQ;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, aliasing, mispredict,
// statistics saturation/clear and reset behaviour.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredictF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        PCSrcE;
  logic [31:0] TargetE;
  logic        PredictedE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic        ClrStats;
  logic [15:0] BranchCnt;
  logic [15:0] MissCnt;

  int checks   = 0;
  int failures = 0;
  int expBranch = 0;
  int expMiss   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PCF(PCF),
    .PredictF(PredictF),
    .PredTargetF(PredTargetF),
    .UpdateE(UpdateE),
    .PCE(PCE),
    .PCSrcE(PCSrcE),
    .TargetE(TargetE),
    .PredictedE(PredictedE),
    .PredTargetE(PredTargetE),
    .MispredictE(MispredictE),
    .ClrStats(ClrStats),
    .BranchCnt(BranchCnt),
    .MissCnt(MissCnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic expPred,
                        input logic [31:0] expTgt);
    PCF = pc;
    #1;
    checkVal({tag, "_pred"}, {31'd0, PredictF}, {31'd0, expPred});
    checkVal({tag, "_tgt"}, PredTargetF, expTgt);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic pred, input logic [31:0] predTgt,
                         input logic expMis);
    @(negedge clk);
    UpdateE     = 1'b1;
    PCE         = pc;
    PCSrcE      = taken;
    TargetE     = tgt;
    PredictedE  = pred;
    PredTargetE = predTgt;
    #1;
    checkVal({tag, "_mis"}, {31'd0, MispredictE}, {31'd0, expMis});
    @(posedge clk);
    #1;
    UpdateE = 1'b0;
    expBranch++;
    if (expMis) expMiss++;
    #1;
    checkVal({tag, "_bcnt"}, {16'd0, BranchCnt}, expBranch);
    checkVal({tag, "_mcnt"}, {16'd0, MissCnt}, expMiss);
  endtask

  initial begin
    // Reset held with a training update and a clear pending
    rst_n = 1'b0; PCF = 32'h40; UpdateE = 1'b1; PCE = 32'h40; PCSrcE = 1'b1;
    TargetE = 32'h80; PredictedE = 1'b0; PredTargetE = 32'h0; ClrStats = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_mis", {31'd0, MispredictE}, 32'd0);
    checkVal("rst_pred", {31'd0, PredictF}, 32'd0);
    checkVal("rst_tgt", PredTargetF, 32'd0);
    checkVal("rst_bcnt", {16'd0, BranchCnt}, 32'd0);
    checkVal("rst_mcnt", {16'd0, MissCnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; UpdateE = 1'b0; ClrStats = 1'b0;
    @(posedge clk);
    #1;
    lookup("post_rst", 32'h40, 1'b0, 32'h0);

    // First taken resolution allocates; lookup in the same cycle sees the old table
    @(negedge clk);
    UpdateE = 1'b1; PCE = 32'h40; PCSrcE = 1'b1; TargetE = 32'h80;
    PredictedE = 1'b0; PredTargetE = 32'h0; PCF = 32'h40;
    #1;
    checkVal("alloc_mis", {31'd0, MispredictE}, 32'd1);
    checkVal("same_cyc_pred", {31'd0, PredictF}, 32'd0);
    @(posedge clk);
    #1;
    UpdateE = 1'b0; expBranch = 1; expMiss = 1;
    #1;
    checkVal("alloc_bcnt", {16'd0, BranchCnt}, 32'd1);
    checkVal("alloc_mcnt", {16'd0, MissCnt}, 32'd1);
    lookup("alloc", 32'h40, 1'b1, 32'h80);

    // Counter walk: WT -> ST -> ST -> WT -> WN
    resolve("tk2", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    resolve("tk3", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    resolve("nt1", 32'h40, 1'b0, 32'h44, 1'b1, 32'h80, 1'b1);
    lookup("nt1", 32'h40, 1'b1, 32'h80);
    resolve("nt2", 32'h40, 1'b0, 32'h44, 1'b1, 32'h80, 1'b1);
    lookup("nt2", 32'h40, 1'b0, 32'h0);

    // Taken with a wrong predicted target; hit moves WN -> WT and retargets
    resolve("tgtmis", 32'h40, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
    lookup("tgtmis", 32'h40, 1'b1, 32'h90);
    resolve("ntok", 32'h40, 1'b0, 32'h44, 1'b0, 32'h0, 1'b0);
    lookup("ntok", 32'h40, 1'b0, 32'h0);

    // Not-taken miss leaves the table alone
    resolve("ntmiss", 32'h44, 1'b0, 32'h48, 1'b0, 32'h0, 1'b0);
    lookup("ntmiss", 32'h44, 1'b0, 32'h0);

    // Aliasing on index 0, and an independent entry on index 1
    resolve("re40", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    lookup("re40", 32'h40, 1'b1, 32'h80);
    resolve("alias", 32'h440, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    lookup("alias_old", 32'h40, 1'b0, 32'h0);
    lookup("alias_new", 32'h440, 1'b1, 32'h100);
    resolve("idx1", 32'h44, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    lookup("idx1", 32'h44, 1'b1, 32'h200);
    lookup("idx0_keep", 32'h440, 1'b1, 32'h100);

    // Mispredict gated by UpdateE
    @(negedge clk);
    UpdateE = 1'b0; PCSrcE = 1'b1; PredictedE = 1'b0;
    #1;
    checkVal("noupd_mis", {31'd0, MispredictE}, 32'd0);

    // Statistics: clear, saturate, clear against a simultaneous update
    @(negedge clk);
    ClrStats = 1'b1;
    @(posedge clk);
    #1;
    ClrStats = 1'b0;
    checkVal("clr_bcnt", {16'd0, BranchCnt}, 32'd0);
    checkVal("clr_mcnt", {16'd0, MissCnt}, 32'd0);
    @(negedge clk);
    UpdateE = 1'b1; PCE = 32'h48; PCSrcE = 1'b0; PredictedE = 1'b0; TargetE = 32'h0;
    repeat (65535) @(posedge clk);
    #1;
    checkVal("sat_reach", {16'd0, BranchCnt}, 32'hFFFF);
    checkVal("sat_mcnt", {16'd0, MissCnt}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("sat_hold", {16'd0, BranchCnt}, 32'hFFFF);
    @(negedge clk);
    ClrStats = 1'b1;
    @(posedge clk);
    #1;
    ClrStats = 1'b0; UpdateE = 1'b0;
    checkVal("clr_win_bcnt", {16'd0, BranchCnt}, 32'd0);
    checkVal("clr_win_mcnt", {16'd0, MissCnt}, 32'd0);
    lookup("ntsat_tbl", 32'h48, 1'b0, 32'h0);
    expBranch = 0; expMiss = 0;
    resolve("postclr", 32'h4C, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    lookup("postclr", 32'h4C, 1'b1, 32'h300);

    // Reset with a training update in flight: discarded, table emptied
    @(negedge clk);
    rst_n = 1'b0; UpdateE = 1'b1; PCE = 32'h50; PCSrcE = 1'b1; TargetE = 32'h500;
    PredictedE = 1'b0; PredTargetE = 32'h0; PCF = 32'h50;
    #1;
    checkVal("inrst_mis", {31'd0, MispredictE}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("rst2_bcnt", {16'd0, BranchCnt}, 32'd0);
    checkVal("rst2_mcnt", {16'd0, MissCnt}, 32'd0);
    lookup("rst2_4c", 32'h4C, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; UpdateE = 1'b0;
    @(posedge clk);
    #1;
    lookup("rst2_50", 32'h50, 1'b0, 32'h0);
    lookup("rst2_440", 32'h440, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
